parking_gate_sequencer: RTL and testbench

Shares the single entry/exit event interface of the `parking` occupancy counter between N entry gates and N exit gates. Each cycle it picks at most one pending gate request and checks it against the counter's vacancy flags and occupancy counts. It then either issues a one-cycle car_entered/car_exited pulse with the gate's uni/free class and acks the gate, or nacks the gate. It sits between the gate barrier controllers and `parking`.

---
 rtl/parking_pkg.sv | 14 +
 rtl/parking_gate_sequencer_rr_arbiter.sv | 30 +++
 rtl/parking_gate_sequencer.sv | 138 +++++++++++++
 tb/tb_parking_gate_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking lot gate sequencer and the
// parking occupancy counter it feeds.
package parking_pkg;

    localparam int N_GATES_DEF = 4;
    localparam int COUNT_W     = 9;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        SETTLE
    } seq_state_e;

endpackage

// File: rtl/parking_gate_sequencer_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping modulo N.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         valid
);

    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!valid && req[j]) begin
                grant[j] = 1'b1;
                idx      = W'(j);
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parking_gate_sequencer.sv
// Serialises N entry and N exit gate requests onto the single event port of
// the parking occupancy counter, one gate per IDLE->ISSUE->SETTLE transaction.
module parking_gate_sequencer
    import parking_pkg::*;
#(
    parameter int N_GATES = N_GATES_DEF,
    parameter int GATE_W  = $clog2(N_GATES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_GATES-1:0] ent_req,
    input  logic [N_GATES-1:0] ent_is_uni,
    output logic [N_GATES-1:0] ent_ack,
    output logic [N_GATES-1:0] ent_nack,
    input  logic [N_GATES-1:0] ext_req,
    input  logic [N_GATES-1:0] ext_is_uni,
    output logic [N_GATES-1:0] ext_ack,
    output logic [N_GATES-1:0] ext_nack,
    input  logic               uni_is_vacated_space,
    input  logic               is_vacated_space,
    input  logic [COUNT_W-1:0] uni_parked_car,
    input  logic [COUNT_W-1:0] parked_car,
    output logic               car_entered,
    output logic               is_uni_car_entered,
    output logic               car_exited,
    output logic               is_uni_car_exited,
    output logic               busy,
    output logic [GATE_W-1:0]  grant_idx
);

    seq_state_e         state;
    logic [GATE_W-1:0]  ent_ptr, ext_ptr;
    logic               last_was_exit;
    logic               srv_exit;

    logic [N_GATES-1:0] ent_grant, ext_grant;
    logic [GATE_W-1:0]  ent_idx, ext_idx;
    logic               ent_valid, ext_valid;

    logic               pick_exit;
    logic [GATE_W-1:0]  sel_idx;
    logic               sel_uni;
    logic               sel_ok;
    logic [GATE_W-1:0]  next_ptr;

    rr_arbiter #(.N(N_GATES), .W(GATE_W)) u_ent_arb (
        .req   (ent_req),
        .ptr   (ent_ptr),
        .grant (ent_grant),
        .idx   (ent_idx),
        .valid (ent_valid)
    );

    rr_arbiter #(.N(N_GATES), .W(GATE_W)) u_ext_arb (
        .req   (ext_req),
        .ptr   (ext_ptr),
        .grant (ext_grant),
        .idx   (ext_idx),
        .valid (ext_valid)
    );

    // Exits win, except right after an exit when entries are also waiting.
    always_comb begin
        pick_exit = ext_valid && !(ent_valid && last_was_exit);
        sel_idx   = pick_exit ? ext_idx : ent_idx;
        sel_uni   = pick_exit ? ext_is_uni[ext_idx] : ent_is_uni[ent_idx];
        if (pick_exit)
            sel_ok = sel_uni ? (uni_parked_car != '0) : (parked_car != '0);
        else
            sel_ok = sel_uni ? uni_is_vacated_space : is_vacated_space;
        next_ptr  = (grant_idx == GATE_W'(N_GATES - 1)) ? '0 : grant_idx + GATE_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            ent_ptr            <= '0;
            ext_ptr            <= '0;
            last_was_exit      <= 1'b0;
            srv_exit           <= 1'b0;
            ent_ack            <= '0;
            ent_nack           <= '0;
            ext_ack            <= '0;
            ext_nack           <= '0;
            car_entered        <= 1'b0;
            is_uni_car_entered <= 1'b0;
            car_exited         <= 1'b0;
            is_uni_car_exited  <= 1'b0;
            busy               <= 1'b0;
            grant_idx          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ent_valid || ext_valid) begin
                        state     <= ISSUE;
                        busy      <= 1'b1;
                        grant_idx <= sel_idx;
                        srv_exit  <= pick_exit;
                        if (pick_exit) begin
                            ext_ack           <= sel_ok ? ext_grant : '0;
                            ext_nack          <= sel_ok ? '0 : ext_grant;
                            car_exited        <= sel_ok;
                            is_uni_car_exited <= sel_ok & sel_uni;
                        end else begin
                            ent_ack            <= sel_ok ? ent_grant : '0;
                            ent_nack           <= sel_ok ? '0 : ent_grant;
                            car_entered        <= sel_ok;
                            is_uni_car_entered <= sel_ok & sel_uni;
                        end
                    end
                end
                ISSUE: begin
                    state              <= SETTLE;
                    ent_ack            <= '0;
                    ent_nack           <= '0;
                    ext_ack            <= '0;
                    ext_nack           <= '0;
                    car_entered        <= 1'b0;
                    is_uni_car_entered <= 1'b0;
                    car_exited         <= 1'b0;
                    is_uni_car_exited  <= 1'b0;
                    grant_idx          <= '0;
                    last_was_exit      <= srv_exit;
                    if (srv_exit)
                        ext_ptr <= next_ptr;
                    else
                        ent_ptr <= next_ptr;
                end
                SETTLE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_parking_gate_sequencer.sv
// Table-driven, hand-sequenced and randomized checks of the gate sequencer
// against a transaction-level reference model.
module tb_parking_gate_sequencer;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] ent_req, ent_is_uni, ext_req, ext_is_uni;
    logic [3:0] ent_ack, ent_nack, ext_ack, ext_nack;
    logic       uni_is_vacated_space, is_vacated_space;
    logic [8:0] uni_parked_car, parked_car;
    logic       car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
    logic       busy;
    logic [1:0] grant_idx;

    parking_gate_sequencer #(.N_GATES(N)) dut (
        .clk(clk), .reset(reset),
        .ent_req(ent_req), .ent_is_uni(ent_is_uni), .ent_ack(ent_ack), .ent_nack(ent_nack),
        .ext_req(ext_req), .ext_is_uni(ext_is_uni), .ext_ack(ext_ack), .ext_nack(ext_nack),
        .uni_is_vacated_space(uni_is_vacated_space), .is_vacated_space(is_vacated_space),
        .uni_parked_car(uni_parked_car), .parked_car(parked_car),
        .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
        .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
        .busy(busy), .grant_idx(grant_idx)
    );

    always #5 clk = ~clk;

    logic [22:0] obs;
    assign obs = {ent_ack, ent_nack, ext_ack, ext_nack, car_entered, is_uni_car_entered,
                  car_exited, is_uni_car_exited, busy, grant_idx};

    localparam logic [22:0] SETTLE_VEC = 23'h000004;

    typedef struct {
        logic [3:0]  er, eu, xr, xu;
        logic        uv, v;
        logic [8:0]  uc, c;
        logic [22:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   passed = 0;
    int   m_ent_ptr, m_ext_ptr;
    bit   m_last;

    function automatic logic [22:0] pk(input logic [3:0] ea, en, xa, xn,
                                       input logic ce, ceu, cx, cxu, input int gi);
        return {ea, en, xa, xn, ce, ceu, cx, cxu, 1'b1, 2'(gi)};
    endfunction

    task automatic add(input logic [3:0] er, eu, xr, xu, input logic uv, v,
                       input int uc, c, input logic [22:0] exp);
        vec_t r;
        r = '{er:er, eu:eu, xr:xr, xu:xu, uv:uv, v:v, uc:9'(uc), c:9'(c), exp:exp};
        tbl.push_back(r);
    endtask

    task automatic drive(input vec_t r);
        ent_req = r.er; ent_is_uni = r.eu; ext_req = r.xr; ext_is_uni = r.xu;
        uni_is_vacated_space = r.uv; is_vacated_space = r.v;
        uni_parked_car = r.uc; parked_car = r.c;
    endtask

    task automatic check(input string name, input logic [22:0] got, input logic [22:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s got=%h want=%h", name, got, want);
    endtask

    // Reference: one served gate per transaction, picked from the current inputs.
    task automatic model_txn(output logic [22:0] exp);
        bit         do_exit;
        logic [3:0] reqv, onehot;
        int         ptr, g;
        bit         uni, ok;
        do_exit = (ext_req != 0) && !((ent_req != 0) && m_last);
        reqv    = do_exit ? ext_req : ent_req;
        ptr     = do_exit ? m_ext_ptr : m_ent_ptr;
        g = -1;
        for (int k = 0; k < N; k++)
            if (g < 0 && reqv[(ptr + k) % N]) g = (ptr + k) % N;
        if (g < 0) begin
            exp = '0;
            return;
        end
        uni    = do_exit ? ext_is_uni[g] : ent_is_uni[g];
        ok     = do_exit ? (uni ? uni_parked_car > 0 : parked_car > 0)
                         : (uni ? uni_is_vacated_space : is_vacated_space);
        onehot = 4'b0001 << g;
        if (do_exit) begin
            exp = pk(4'b0, 4'b0, ok ? onehot : 4'b0, ok ? 4'b0 : onehot, 0, 0, ok, ok & uni, g);
            m_ext_ptr = (g + 1) % N;
        end else begin
            exp = pk(ok ? onehot : 4'b0, ok ? 4'b0 : onehot, 4'b0, 4'b0, ok, ok & uni, 0, 0, g);
            m_ent_ptr = (g + 1) % N;
        end
        m_last = do_exit;
    endtask

    task automatic run_txn(input string name, input logic [22:0] exp, input int mode);
        @(posedge clk); #1;
        check({name, "_issue"}, obs, exp);
        if (mode == 1) begin
            ent_req = 4'($urandom); ext_req = 4'($urandom);
        end else if (mode == 2) begin
            ent_req = '0; ext_req = '0;
        end
        @(posedge clk); #1;
        check({name, "_settle"}, obs, SETTLE_VEC);
        @(posedge clk); #1;
        check({name, "_idle"}, obs, 23'h0);
    endtask

    initial begin
        logic [22:0] e;
        vec_t        r;

        add(4'b1111, 4'b0000, 4'b1111, 4'b0000, 1, 1, 5, 5, pk(0, 0, 4'b0001, 0, 0, 0, 1, 0, 0));
        add(4'b1111, 4'b0000, 4'b1111, 4'b0000, 1, 1, 5, 5, pk(4'b0001, 0, 0, 0, 1, 0, 0, 0, 0));
        add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1, 0, 5, 5, pk(4'b0001, 0, 0, 0, 1, 1, 0, 0, 0));
        add(4'b0010, 4'b0000, 4'b0000, 4'b0000, 1, 0, 5, 5, pk(0, 4'b0010, 0, 0, 0, 0, 0, 0, 1));
        for (int g = 2; g < 7; g++)
            add(4'b1111, 4'b0000, 4'b0000, 4'b0000, 1, 1, 5, 5,
                pk(4'b0001 << (g % 4), 0, 0, 0, 1, 0, 0, 0, g % 4));
        add(4'b0001, 4'b0000, 4'b0001, 4'b0001, 1, 1, 5, 5, pk(0, 0, 4'b0001, 0, 0, 0, 1, 1, 0));
        add(4'b0001, 4'b0000, 4'b0001, 4'b0001, 1, 1, 5, 5, pk(4'b0001, 0, 0, 0, 1, 0, 0, 0, 0));
        add(4'b0001, 4'b0000, 4'b0001, 4'b0001, 1, 1, 5, 5, pk(0, 0, 4'b0001, 0, 0, 0, 1, 1, 0));
        add(4'b0000, 4'b0000, 4'b0100, 4'b0000, 1, 1, 5, 0, pk(0, 0, 0, 4'b0100, 0, 0, 0, 0, 2));
        add(4'b0000, 4'b0000, 4'b1000, 4'b1000, 1, 1, 0, 5, pk(0, 0, 0, 4'b1000, 0, 0, 0, 0, 3));

        m_ent_ptr = 0; m_ext_ptr = 0; m_last = 0;
        reset = 1'b0;
        drive(tbl[0]);
        @(posedge clk); #1;
        check("reset_hold0", obs, 23'h0);
        @(posedge clk); #1;
        check("reset_hold1", obs, 23'h0);
        @(negedge clk);
        reset = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i]);
            model_txn(e);
            run_txn($sformatf("row%0d", i), tbl[i].exp, 0);
        end

        // Reset while an admission pulse is on the wire.
        ent_req = 4'b0001; ent_is_uni = 4'b0000; ext_req = '0; is_vacated_space = 1'b1;
        model_txn(e);
        @(posedge clk); #1;
        check("pre_reset_issue", obs, e);
        #2 reset = 1'b0;
        #1 check("reset_mid_issue", obs, 23'h0);
        @(posedge clk); #1;
        check("reset_mid_hold", obs, 23'h0);
        @(negedge clk);
        reset = 1'b1;
        m_ent_ptr = 0; m_ext_ptr = 0; m_last = 0;

        // Request withdrawn during ISSUE is not served again.
        ent_req = 4'b0100; ext_req = '0;
        model_txn(e);
        run_txn("withdraw", e, 2);
        @(posedge clk); #1;
        check("withdraw_quiet", obs, 23'h0);

        for (int t = 0; t < 150; t++) begin
            r.er = 4'($urandom); r.eu = 4'($urandom);
            r.xr = 4'($urandom); r.xu = 4'($urandom);
            if (r.er == 0 && r.xr == 0) r.er = 4'b0001 << $urandom_range(0, 3);
            r.uv = 1'($urandom); r.v = 1'($urandom);
            r.uc = ($urandom_range(0, 2) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
            r.c  = ($urandom_range(0, 2) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
            r.exp = '0;
            drive(r);
            model_txn(e);
            run_txn($sformatf("rnd%0d", t), e, 1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
